// File: rtl/pmips_seqmul.sv
// Sequential signed multiplier for the picoMIPS datapath: radix-2 shift-add on operand
// magnitudes over n cycles, sign fix-up and half-select on the edge entering DONE.
module pmips_seqmul #(
    parameter int unsigned n = 8
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic         start,
    input  logic         mode,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] Wdata,
    output logic         w,
    output logic         busy
);

    localparam int unsigned DW = 2 * n;
    localparam int unsigned CW = $clog2(n + 1);
    localparam logic [CW-1:0] LastIter = CW'(n - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic          sign_q, sign_d;
    logic          mode_q, mode_d;
    logic [n-1:0]  mag_a_q, mag_a_d;
    logic [n-1:0]  mag_b_q, mag_b_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  wdata_q, wdata_d;

    logic [DW-1:0] addend;
    logic [DW-1:0] acc_sum;
    logic [DW-1:0] prod;

    // Two's complement magnitude; the most negative value maps to 2^(n-1), which fits unsigned.
    function automatic logic [n-1:0] magnitude(input logic [n-1:0] v);
        logic [n-1:0] r;
        r = v[n-1] ? (~v + {{(n-1){1'b0}}, 1'b1}) : v;
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (cnt_q == LastIter) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        busy  = (state_q != StIdle);
        w     = (state_q == StDone);
        Wdata = wdata_q;
    end

    // Datapath next-state
    always_comb begin
        sign_d  = sign_q;
        mode_d  = mode_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;

        addend  = mag_b_q[0] ? (DW'(mag_a_q) << cnt_q) : '0;
        acc_sum = acc_q + addend;
        // The final product is formed from this cycle's sum so the result lands on the DONE edge.
        prod    = sign_q ? (~acc_sum + DW'(1)) : acc_sum;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sign_d  = a[n-1] ^ b[n-1];
                    mag_a_d = magnitude(a);
                    mag_b_d = magnitude(b);
                    mode_d  = mode;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                acc_d   = acc_sum;
                mag_b_d = mag_b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LastIter) begin
                    wdata_d = mode_q ? prod[DW-1:n] : prod[n-1:0];
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sign_q  <= 1'b0;
            mode_q  <= 1'b0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
        end else begin
            sign_q  <= sign_d;
            mode_q  <= mode_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_pmips_seqmul.sv
// Directed self-checking bench for pmips_seqmul (n=8): latency, signed halves, extremes,
// start protection, back-to-back spacing and asynchronous abort.
module tb_pmips_seqmul;

    localparam int unsigned N = 8;

    logic         clk;
    logic         nReset;
    logic         start;
    logic         mode;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] Wdata;
    logic         w;
    logic         busy;

    int checks;
    int failures;

    pmips_seqmul #(.n(N)) dut (
        .clk   (clk),
        .nReset(nReset),
        .start (start),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .Wdata (Wdata),
        .w     (w),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then expect w exactly n+1 edges later with busy high throughout.
    task automatic run_mul(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                           input logic md, input logic [N-1:0] exp);
        int lat;
        int busy_cycles;
        a = av;
        b = bv;
        mode = md;
        start = 1'b1;
        step();
        start = 1'b0;
        a = ~av;
        b = ~bv;
        mode = ~md;
        lat = 0;
        busy_cycles = busy ? 1 : 0;
        for (int i = 1; i <= 20; i++) begin
            if (w) break;
            step();
            lat = i;
            if (busy) busy_cycles++;
        end
        chk({tag, "_latency"}, lat, N);
        chk({tag, "_wdata"}, Wdata, exp);
        chk({tag, "_busy_cycles"}, busy_cycles, N + 1);
        step();
        chk({tag, "_w_drop"}, {busy, w}, 2'b00);
    endtask

    initial begin
        int w_count;
        int t;
        int first_w;
        int second_w;
        logic saw_bad;

        checks = 0;
        failures = 0;
        nReset = 1'b0;
        start = 1'b0;
        mode = 1'b0;
        a = '0;
        b = '0;

        // Reset held: outputs stay quiet regardless of inputs
        saw_bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start = ~start;
            a = N'($urandom);
            b = N'($urandom);
            step();
            if (Wdata !== '0 || w !== 1'b0 || busy !== 1'b0) saw_bad = 1'b1;
        end
        chk("reset_quiet", saw_bad, 1'b0);
        chk("reset_outputs", {Wdata, w, busy}, 10'h000);
        start = 1'b0;
        nReset = 1'b1;
        step();
        chk("post_reset_idle", {w, busy}, 2'b00);

        run_mul("low_7x3", 8'd7, 8'd3, 1'b0, 8'h15);
        run_mul("hi_m5x3", 8'hFB, 8'd3, 1'b1, 8'hFF);
        run_mul("lo_m5x3", 8'hFB, 8'd3, 1'b0, 8'hF1);
        run_mul("hi_80x80", 8'h80, 8'h80, 1'b1, 8'h40);
        run_mul("lo_80x80", 8'h80, 8'h80, 1'b0, 8'h00);
        run_mul("hi_100x100", 8'd100, 8'd100, 1'b1, 8'h27);
        run_mul("lo_m7x5", 8'hF9, 8'd5, 1'b0, 8'hDD);
        run_mul("lo_0x77", 8'h00, 8'h77, 1'b0, 8'h00);

        // Start pulses during RUN must be ignored
        a = 8'd7;
        b = 8'd3;
        mode = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        w_count = 0;
        for (int i = 1; i <= 24; i++) begin
            if (i == 2 || i == 5) begin
                a = 8'd50;
                b = 8'd9;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            if (w) begin
                w_count++;
                chk("protect_wdata", Wdata, 8'h15);
            end
        end
        chk("protect_single_w", w_count, 1);

        // start held high: completions every n+2 cycles
        a = 8'd5;
        b = 8'd6;
        mode = 1'b0;
        start = 1'b1;
        first_w = -1;
        second_w = -1;
        for (t = 1; t <= 30; t++) begin
            step();
            if (w) begin
                if (first_w < 0) first_w = t;
                else if (second_w < 0) second_w = t;
            end
        end
        start = 1'b0;
        chk("b2b_spacing", second_w - first_w, N + 2);
        chk("b2b_wdata", Wdata, 8'd30);
        for (int i = 0; i < 12; i++) step();
        chk("b2b_drained", {w, busy}, 2'b00);

        // Asynchronous abort on RUN cycle 4
        a = 8'd9;
        b = 8'd9;
        mode = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("abort_busy_before", busy, 1'b1);
        #2;
        nReset = 1'b0;
        #1;
        chk("abort_immediate", {Wdata, w, busy}, 10'h000);
        saw_bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (w !== 1'b0 || Wdata !== '0) saw_bad = 1'b1;
        end
        nReset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (w !== 1'b0 || Wdata !== '0) saw_bad = 1'b1;
        end
        chk("abort_no_write", saw_bad, 1'b0);
        run_mul("after_abort", 8'd100, 8'd100, 1'b1, 8'h27);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
